// File: rtl/exec_stage_mc.sv
// exec_stage_mc: registered WISC execute stage with operand forwarding, valid/ready
// handshake and an iterative shift-add multiplier. Define EXEC_STAGE_MC_MULHI_EN for result_hi.
module exec_stage_mc #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [1:0]       func,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_src,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [WIDTH-1:0] em_result,
  input  logic [WIDTH-1:0] mw_result,
  input  logic [WIDTH-1:0] inc_pc,
  input  logic             branch,
  input  logic             jump,
  input  logic             jump_reg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] next_pc,
  output logic             taken,
  output logic             err,
`ifdef EXEC_STAGE_MC_MULHI_EN
  output logic [WIDTH-1:0] result_hi,
`endif
  output logic             busy
);

`ifdef EXEC_STAGE_MC_MULHI_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_WAIT = 2'd2} state_t;

  state_t           state;
  logic [CW-1:0]    cnt_p1;
  logic [ACC_W-1:0] acc_p1;
  logic [WIDTH-1:0] mul_a_p1, mul_b_p1, pend_npc_p1;
  logic             pend_taken_p1, pend_err_p1;

  logic signed [WIDTH-1:0] a_p0, b_p0;
  logic [WIDTH-1:0] alu_p0, npc_p0;
  logic             cond_p0, taken_p0, err_p0, accept_p0, is_mul_p0, out_free;

  // Overflow-safe signed compare: differing signs decide directly, else sign of A-B.
  function automatic logic slt_f(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] d;
    d = a - b;
    return (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : d[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] btr_f(input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = a[WIDTH-1-i];
    return r;
  endfunction

  // Stage p0: operand selection, ALU, branch resolution
  always_comb begin
    case (fwd_a)
      2'b00:   a_p0 = op_a;
      2'b01:   a_p0 = mw_result;
      2'b10:   a_p0 = em_result;
      default: a_p0 = '0;
    endcase
    case (fwd_b)
      2'b00:   b_p0 = alu_src ? imm : op_b;
      2'b01:   b_p0 = mw_result;
      2'b10:   b_p0 = em_result;
      default: b_p0 = '0;
    endcase
    err_p0 = (fwd_a == 2'b11) | (fwd_b == 2'b11);

    case (opcode)
      3'b000:  alu_p0 = a_p0 + b_p0;
      3'b001:  alu_p0 = a_p0 - b_p0;
      3'b010:  alu_p0 = a_p0 & b_p0;
      3'b011:  alu_p0 = a_p0 ^ b_p0;
      3'b100:  alu_p0 = {{(WIDTH-1){1'b0}}, slt_f(a_p0, b_p0)};
      3'b101:  alu_p0 = {{(WIDTH-1){1'b0}}, (a_p0 == b_p0)};
      3'b111:  alu_p0 = btr_f(a_p0);
      default: alu_p0 = '0;
    endcase

    case (func)
      2'b00:   cond_p0 = (a_p0 == '0);
      2'b01:   cond_p0 = (a_p0 != '0);
      2'b10:   cond_p0 = a_p0[WIDTH-1];
      default: cond_p0 = ~a_p0[WIDTH-1];
    endcase
    taken_p0 = jump_reg | jump | (branch & cond_p0);
    if (jump_reg)
      npc_p0 = a_p0 + imm;
    else if ((branch & cond_p0) | jump)
      npc_p0 = inc_pc + imm;
    else
      npc_p0 = inc_pc;
  end

  assign out_free  = ~out_valid | out_ready;
  assign in_ready  = (state == S_IDLE) & out_free & ~flush;
  assign accept_p0 = in_valid & in_ready;
  assign is_mul_p0 = (opcode == 3'b110);
  assign busy      = (state != S_IDLE);

  // Stage p1: multiplier operand capture (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept_p0 && is_mul_p0) begin
      mul_a_p1      <= a_p0;
      mul_b_p1      <= b_p0;
      pend_npc_p1   <= npc_p0;
      pend_taken_p1 <= taken_p0;
      pend_err_p1   <= err_p0;
    end
  end

  // Stage p1: control FSM, shift-add iteration and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt_p1    <= '0;
      acc_p1    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      next_pc   <= '0;
      taken     <= 1'b0;
      err       <= 1'b0;
`ifdef EXEC_STAGE_MC_MULHI_EN
      result_hi <= '0;
`endif
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      // A load below overrides this drain.
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_p0) begin
            if (is_mul_p0) begin
              cnt_p1 <= '0;
              acc_p1 <= '0;
              state  <= S_MUL;
            end else begin
              result    <= alu_p0;
              next_pc   <= npc_p0;
              taken     <= taken_p0;
              err       <= err_p0;
              out_valid <= 1'b1;
`ifdef EXEC_STAGE_MC_MULHI_EN
              result_hi <= '0;
`endif
            end
          end
        end
        S_MUL: begin
          if (mul_b_p1[cnt_p1]) acc_p1 <= acc_p1 + (ACC_W'(mul_a_p1) << cnt_p1);
          cnt_p1 <= cnt_p1 + 1'b1;
          if (cnt_p1 == CW'(MUL_CYCLES - 1)) state <= S_WAIT;
        end
        S_WAIT: begin
          if (out_free) begin
            result    <= acc_p1[WIDTH-1:0];
            next_pc   <= pend_npc_p1;
            taken     <= pend_taken_p1;
            err       <= pend_err_p1;
            out_valid <= 1'b1;
`ifdef EXEC_STAGE_MC_MULHI_EN
            result_hi <= acc_p1[ACC_W-1:WIDTH];
`endif
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Self-checking bench for exec_stage_mc: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_exec_stage_mc;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, alu_src, branch, jump, jump_reg;
  logic out_valid, out_ready, taken, err, busy;
  logic [2:0] opcode;
  logic [1:0] func, fwd_a, fwd_b;
  logic [W-1:0] op_a, op_b, imm, em_result, mw_result, inc_pc, result, next_pc;
`ifdef EXEC_STAGE_MC_MULHI_EN
  logic [W-1:0] result_hi;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state: visible outputs plus a pending multiply with a cycle countdown.
  logic         m_ov, m_taken, m_err;
  logic [W-1:0] m_res, m_hi, m_npc;
  int           m_rem;
  logic [W-1:0] p_res, p_hi, p_npc;
  logic         p_taken, p_err;

  exec_stage_mc #(.WIDTH(W), .MUL_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func(func), .op_a(op_a), .op_b(op_b), .imm(imm), .alu_src(alu_src),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .em_result(em_result), .mw_result(mw_result),
    .inc_pc(inc_pc), .branch(branch), .jump(jump), .jump_reg(jump_reg),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .next_pc(next_pc),
    .taken(taken), .err(err),
`ifdef EXEC_STAGE_MC_MULHI_EN
    .result_hi(result_hi),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] sel(input logic [1:0] f, input logic [W-1:0] r);
    case (f)
      2'd0: return r;
      2'd1: return mw_result;
      2'd2: return em_result;
      default: return '0;
    endcase
  endfunction

  task automatic eval(output logic [W-1:0] r, output logic [W-1:0] h, output logic [W-1:0] n,
                      output logic tk, output logic er);
    logic [W-1:0] a, b;
    logic [2*W-1:0] prod;
    logic c;
    a = sel(fwd_a, op_a);
    b = sel(fwd_b, alu_src ? imm : op_b);
    er = (fwd_a == 2'd3) || (fwd_b == 2'd3);
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    h = '0;
    case (opcode)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: r = ($signed(a) < $signed(b)) ? 1 : 0;
      3'd5: r = (a == b) ? 1 : 0;
      3'd6: begin r = prod[W-1:0]; h = prod[2*W-1:W]; end
      default: for (int i = 0; i < W; i++) r[i] = a[W-1-i];
    endcase
    case (func)
      2'd0: c = (a == 0);
      2'd1: c = (a != 0);
      2'd2: c = $signed(a) < 0;
      default: c = $signed(a) >= 0;
    endcase
    tk = jump_reg || jump || (branch && c);
    n = jump_reg ? a + imm : (tk ? inc_pc + imm : inc_pc);
  endtask

  function automatic logic exp_ready();
    return (m_rem == 0) && (!m_ov || out_ready) && !flush;
  endfunction

  task automatic model_reset();
    m_ov = 0; m_taken = 0; m_err = 0; m_res = 0; m_hi = 0; m_npc = 0; m_rem = 0;
  endtask

  task automatic model_step();
    logic acc, loaded, ov_old, tk, er;
    logic [W-1:0] r, h, n;
    acc = in_valid && exp_ready();
    ov_old = m_ov;
    loaded = 0;
    if (flush) begin
      m_rem = 0; m_ov = 0; m_err = 0;
    end else begin
      if (m_rem > 1) m_rem--;
      else if (m_rem == 1 && (!m_ov || out_ready)) begin
        m_res = p_res; m_hi = p_hi; m_npc = p_npc; m_taken = p_taken; m_err = p_err;
        m_rem = 0; loaded = 1;
      end
      if (acc) begin
        eval(r, h, n, tk, er);
        if (opcode == 3'd6) begin
          p_res = r; p_hi = h; p_npc = n; p_taken = tk; p_err = er; m_rem = W + 1;
        end else begin
          m_res = r; m_hi = 0; m_npc = n; m_taken = tk; m_err = er; loaded = 1;
        end
      end
      if (loaded) m_ov = 1;
      else if (ov_old && out_ready) m_ov = 0;
    end
  endtask

  // One clock: check in_ready before the edge, advance model, compare all outputs after it.
  task automatic tick();
    #1;
    chk("in_ready", in_ready, exp_ready());
    model_step();
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("busy", busy, m_rem != 0);
    chk("err", err, m_err);
    if (m_ov) begin
      chk("result", result, m_res);
      chk("next_pc", next_pc, m_npc);
      chk("taken", taken, m_taken);
`ifdef EXEC_STAGE_MC_MULHI_EN
      chk("result_hi", result_hi, m_hi);
`endif
    end
  endtask

  task automatic clear_in();
    flush = 0; in_valid = 0; opcode = 0; func = 0; op_a = 0; op_b = 0; imm = 0; alu_src = 0;
    fwd_a = 0; fwd_b = 0; em_result = 0; mw_result = 0; inc_pc = 0; branch = 0; jump = 0;
    jump_reg = 0; out_ready = 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_next_pc"}, next_pc, 0);
    chk({tag, "_taken"}, taken, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef EXEC_STAGE_MC_MULHI_EN
    chk({tag, "_result_hi"}, result_hi, 0);
`endif
  endtask

  function automatic logic [W-1:0] rv();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    clear_in();
    model_reset();
    p_res = 0; p_hi = 0; p_npc = 0; p_taken = 0; p_err = 0;
    rst = 1;
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 0;

    // add 5+3
    in_valid = 1; opcode = 3'd0; op_a = 16'h0005; op_b = 16'h0003; inc_pc = 16'h0102;
    tick();
    chk("add_lit", result, 16'h0008);
    chk("add_npc_lit", next_pc, 16'h0102);
    chk("add_taken_lit", taken, 0);

    // forwarded A from EX/MEM plus immediate
    fwd_a = 2'd2; em_result = 16'h7FFF; imm = 16'h0001; alu_src = 1;
    tick();
    chk("fwd_add_lit", result, 16'h8000);
    fwd_a = 2'd3;
    tick();
    chk("fwd_err_lit", err, 1);

    // slt across the sign boundary
    fwd_a = 0; alu_src = 0; opcode = 3'd4; op_a = 16'h8000; op_b = 16'h0001;
    tick();
    chk("slt1_lit", result, 16'h0001);
    op_a = 16'h7FFF; op_b = 16'hFFFF;
    tick();
    chk("slt2_lit", result, 16'h0000);

    // multiply 0x0123 * 0x0045
    opcode = 3'd6; op_a = 16'h0123; op_b = 16'h0045;
    tick();
    in_valid = 0;
    chk("mul_busy0", busy, 1);
    for (int i = 1; i <= W; i++) begin
      tick();
      chk("mul_busy_lit", busy, 1);
      chk("mul_inrdy_lit", in_ready, 0);
    end
    tick();
    chk("mul_res_lit", result, 16'h4E6F);
    chk("mul_done_busy", busy, 0);
`ifdef EXEC_STAGE_MC_MULHI_EN
    chk("mul_hi_lit", result_hi, 16'h0000);
`endif
    in_valid = 1; op_a = 16'hFFFF; op_b = 16'hFFFF;
    tick();
    in_valid = 0;
    for (int i = 0; i <= W; i++) tick();
    chk("mulff_res_lit", result, 16'h0001);
`ifdef EXEC_STAGE_MC_MULHI_EN
    chk("mulff_hi_lit", result_hi, 16'hFFFE);
`endif

    // backpressure: held output, then pass-through
    in_valid = 1; opcode = 3'd0; op_a = 16'h0010; op_b = 16'h0020;
    tick();
    out_ready = 0; opcode = 3'd1; op_a = 16'h0100; op_b = 16'h0001;
    tick();
    chk("bp_hold_lit", result, 16'h0030);
    tick();
    chk("bp_hold2_lit", result, 16'h0030);
    out_ready = 1;
    tick();
    chk("bp_pass_lit", result, 16'h00FF);

    // branch on forwarded zero
    opcode = 3'd0; branch = 1; func = 2'd0; fwd_a = 2'd1; mw_result = 0;
    imm = 16'h0010; inc_pc = 16'h0200;
    tick();
    chk("br_taken_lit", taken, 1);
    chk("br_npc_lit", next_pc, 16'h0210);
    branch = 0; fwd_a = 0;

    // flush in the fifth cycle of a multiply
    opcode = 3'd6; op_a = 16'h1234; op_b = 16'h5678;
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush_busy_lit", busy, 0);
    chk("flush_ov_lit", out_valid, 0);

    // asynchronous reset mid-multiply
    in_valid = 1;
    tick();
    in_valid = 0;
    tick(); tick();
    #2 rst = 1;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    #1 rst = 0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      opcode = 3'($urandom_range(0, 7));
      if (opcode == 3'd6 && $urandom_range(0, 2) != 0) opcode = 3'd0;
      func = 2'($urandom);
      op_a = rv(); op_b = rv(); imm = rv(); em_result = rv(); mw_result = rv(); inc_pc = rv();
      alu_src = 1'($urandom);
      fwd_a = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      fwd_b = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      branch = 1'($urandom); jump = ($urandom_range(0, 5) == 0);
      jump_reg = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
